// File: rtl/fpadd_share_arb.sv
// fpadd_share_arb
// Shares one pipelined 16-bit adder between NREQ requesters. A round-robin
// arbiter issues at most one operand pair per cycle. A tag shift register
// follows each issue through the adder latency, so that every result lands
// in the result register of the requester that issued it.
module fpadd_share_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic               clkk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    res_valid,
  input  logic [NREQ-1:0]    res_ready,
  output logic [16*NREQ-1:0] res_data,
  output logic [NREQ-1:0]    res_ovf,
  output logic [15:0]        fpa_a,
  output logic [15:0]        fpa_b,
  output logic               fpa_in_valid,
  input  logic [15:0]        fpa_res,
  input  logic               fpa_ovf,
  output logic               busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } slot_t;

  slot_t         slot     [NREQ];
  slot_t         slot_nxt [NREQ];
  logic [NREQ-1:0] slot_busy;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] cand;
  logic [IW-1:0] grant_idx;
  logic          grant_any;
  logic          grant_ok;
  logic          hit;

  // Stage 0 holds the tag of the op currently on fpa_a/fpa_b; stage LAT
  // lines up with the cycle in which fpa_res carries that op's result.
  logic          tag_v [LAT+1];
  logic [IW-1:0] tag_i [LAT+1];
  logic [NREQ-1:0] cap_hit;

  // Index (base + off) modulo NREQ, with off < NREQ
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    sum = (sum >= 32'(NREQ)) ? (sum - 32'(NREQ)) : sum;
    return sum[IW-1:0];
  endfunction

  // Round-robin search from rr_ptr for the first valid requester whose slot is idle
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    hit       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand      = wrap_add(rr_ptr, k);
      hit       = !grant_any && req_valid[cand] && (slot[cand] == S_IDLE);
      grant_idx = hit ? cand : grant_idx;
      grant_any = grant_any | hit;
    end
    // Nothing is accepted while reset is applied
    grant_ok = grant_any & ~rst;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant_ok & (grant_idx == IW'(i));
    end
  end

  // Round-robin pointer moves just past the requester granted this cycle
  always_ff @(posedge clkk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_ok) begin
      rr_ptr <= wrap_add(grant_idx, 1);
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

  // Operand register that drives the shared adder; operands hold on idle cycles
  always_ff @(posedge clkk or posedge rst) begin
    if (rst) begin
      fpa_a        <= 16'h0000;
      fpa_b        <= 16'h0000;
      fpa_in_valid <= 1'b0;
    end else if (grant_ok) begin
      fpa_a        <= req_a[{grant_idx, 4'b0000} +: 16];
      fpa_b        <= req_b[{grant_idx, 4'b0000} +: 16];
      fpa_in_valid <= 1'b1;
    end else begin
      fpa_in_valid <= 1'b0;
    end
  end

  // Tag shift register; a bubble is shifted in on cycles without a grant
  always_ff @(posedge clkk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= LAT; s++) begin
        tag_v[s] <= 1'b0;
        tag_i[s] <= '0;
      end
    end else begin
      tag_v[0] <= grant_ok;
      tag_i[0] <= grant_idx;
      for (int s = 1; s <= LAT; s++) begin
        tag_v[s] <= tag_v[s-1];
        tag_i[s] <= tag_i[s-1];
      end
    end
  end

  // Decode the exiting tag into a per-requester capture strobe
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cap_hit[i] = tag_v[LAT] & (tag_i[LAT] == IW'(i));
    end
  end

  // Result capture into the owning requester's register; held until the next capture
  always_ff @(posedge clkk or posedge rst) begin
    if (rst) begin
      res_data <= '0;
      res_ovf  <= '0;
    end else if (tag_v[LAT]) begin
      res_data[{tag_i[LAT], 4'b0000} +: 16] <= fpa_res;
      res_ovf[tag_i[LAT]]                   <= fpa_ovf;
    end else begin
      res_data <= res_data;
      res_ovf  <= res_ovf;
    end
  end

  // Slot state register
  always_ff @(posedge clkk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        slot[i] <= S_IDLE;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        slot[i] <= slot_nxt[i];
      end
    end
  end

  // Slot next-state: accept -> in flight -> result held -> consumed
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      slot_nxt[i] = slot[i];
      case (slot[i])
        S_IDLE:  slot_nxt[i] = req_ready[i] ? S_BUSY : S_IDLE;
        S_BUSY:  slot_nxt[i] = cap_hit[i]   ? S_DONE : S_BUSY;
        S_DONE:  slot_nxt[i] = res_ready[i] ? S_IDLE : S_DONE;
        default: slot_nxt[i] = S_IDLE;
      endcase
    end
  end

  // Slot outputs decoded from registered state only
  always_comb begin
    busy      = 1'b0;
    res_valid = '0;
    slot_busy = '0;
    for (int i = 0; i < NREQ; i++) begin
      res_valid[i] = (slot[i] == S_DONE);
      slot_busy[i] = (slot[i] == S_BUSY);
      busy         = busy | (slot[i] != S_IDLE);
    end
  end

  // A result may only be routed to a slot that is waiting for it
  cap_only_busy: assert property (@(posedge clkk) disable iff (rst)
    ((cap_hit & ~slot_busy) == '0));

endmodule

// File: tb/tb_fpadd_share_arb.sv
// tb_fpadd_share_arb
// Directed stimulus for fpadd_share_arb with a timer-based reference model
// compared every cycle, plus hand-computed expectations for each scenario.
module tb_fpadd_share_arb;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic               clkk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [NREQ-1:0]    res_valid;
  logic [NREQ-1:0]    res_ready;
  logic [16*NREQ-1:0] res_data;
  logic [NREQ-1:0]    res_ovf;
  logic [15:0]        fpa_a;
  logic [15:0]        fpa_b;
  logic               fpa_in_valid;
  logic [15:0]        fpa_res;
  logic               fpa_ovf;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  fpadd_share_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clkk(clkk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf),
    .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_in_valid(fpa_in_valid),
    .fpa_res(fpa_res), .fpa_ovf(fpa_ovf),
    .busy(busy)
  );

  always #5 clkk = ~clkk;

  always @(posedge clkk) cyc <= cyc + 1;

  // Stand-in adder: LAT-cycle delay, result = a ^ b, overflow = &a[15:11]
  logic [15:0] pa [LAT];
  logic [15:0] pb [LAT];
  always @(posedge clkk) begin
    pa[0] <= fpa_a;
    pb[0] <= fpa_b;
    for (int s = 1; s < LAT; s++) begin
      pa[s] <= pa[s-1];
      pb[s] <= pb[s-1];
    end
  end
  assign fpa_res = pa[LAT-1] ^ pb[LAT-1];
  assign fpa_ovf = &pa[LAT-1][15:11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // m_state: 0 idle, 1 in flight, 2 result held
  int          m_state [NREQ];
  int          m_cnt   [NREQ];
  logic [15:0] m_data  [NREQ];
  logic [15:0] m_pend  [NREQ];
  logic        m_ovf   [NREQ];
  logic        m_povf  [NREQ];
  int          m_ptr;
  logic [15:0] m_fa, m_fb;
  logic        m_fv;

  function automatic int exp_grant();
    int idx;
    if (rst) return -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx] && m_state[idx] == 0) return idx;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREQ; i++) begin
      m_state[i] = 0; m_cnt[i] = 0; m_data[i] = 16'h0000;
      m_pend[i] = 16'h0000; m_ovf[i] = 1'b0; m_povf[i] = 1'b0;
    end
    m_ptr = 0; m_fa = 16'h0000; m_fb = 16'h0000; m_fv = 1'b0;
  endtask

  task automatic model_compare();
    int g;
    logic [NREQ-1:0] er, ev, eo;
    logic eb;
    g = exp_grant();
    er = '0; ev = '0; eo = '0; eb = 1'b0;
    if (g >= 0) er[g] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      ev[i] = (m_state[i] == 2);
      eo[i] = m_ovf[i];
      if (m_state[i] != 0) eb = 1'b1;
      check($sformatf("model_res_data%0d", i), res_data[16*i +: 16], m_data[i]);
    end
    check("model_req_ready", req_ready, er);
    check("model_res_valid", res_valid, ev);
    check("model_res_ovf", res_ovf, eo);
    check("model_busy", busy, eb);
    check("model_fpa_in_valid", fpa_in_valid, m_fv);
    check("model_fpa_a", fpa_a, m_fa);
    check("model_fpa_b", fpa_b, m_fb);
  endtask

  // Advance the model across the coming rising edge
  task automatic model_step();
    int g;
    logic [15:0] a, b;
    g = exp_grant();
    for (int i = 0; i < NREQ; i++)
      if (m_state[i] == 2 && res_ready[i]) m_state[i] = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (m_state[i] == 1) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          m_state[i] = 2; m_data[i] = m_pend[i]; m_ovf[i] = m_povf[i];
        end
      end
    end
    if (g >= 0) begin
      a = req_a[16*g +: 16];
      b = req_b[16*g +: 16];
      m_state[g] = 1; m_cnt[g] = LAT + 1;
      m_pend[g] = a ^ b; m_povf[g] = &a[15:11];
      m_ptr = (g + 1) % NREQ;
      m_fa = a; m_fb = b; m_fv = 1'b1;
    end else begin
      m_fv = 1'b0;
    end
  endtask

  // Compare process: check on the falling edge, then advance the model
  initial begin
    model_clear();
    forever begin
      @(negedge clkk);
      if (rst) model_clear();
      model_compare();
      if (!rst) model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clkk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  int g0, g1;
  logic [3:0] onehot;

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = '1;
    #3;
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_res_valid", res_valid, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_fpa_in_valid", fpa_in_valid, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // T1: single op from requester 2
    set_op(2, 16'h3C00, 16'h0001);
    req_valid = 4'b0100;
    #3 check("t1_ready", req_ready, 4'b0100);
    tick(); req_valid = 4'b0000;
    #3 check("t1_fpa_in_valid", fpa_in_valid, 1'b1);
    check("t1_fpa_a", fpa_a, 16'h3C00);
    check("t1_fpa_b", fpa_b, 16'h0001);
    tick(); tick();
    #3 check("t1_res_valid_early", res_valid, 4'b0000);
    tick();
    #3 check("t1_res_valid", res_valid, 4'b0100);
    check("t1_res_data", res_data[47:32], 16'h3C01);
    check("t1_res_ovf", res_ovf[2], 1'b0);
    tick();
    #3 check("t1_res_valid_after", res_valid, 4'b0000);
    check("t1_res_data_hold", res_data[47:32], 16'h3C01);

    // T2: all four valid with rr_ptr at 0
    rst = 1'b1; tick(); rst = 1'b0; tick();
    set_op(0, 16'h1111, 16'h00F0);
    set_op(1, 16'h2222, 16'h00F0);
    set_op(2, 16'h3333, 16'h00F0);
    set_op(3, 16'h4444, 16'h00F0);
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      onehot = 4'b0001 << k;
      #3 check($sformatf("t2_grant%0d", k), req_ready, onehot);
      tick();
    end
    req_valid = 4'b0000;
    #3 check("t2_res_valid0", res_valid, 4'b0001);
    check("t2_res_data0", res_data[15:0], 16'h11E1);
    tick();
    #3 check("t2_res_valid1", res_valid, 4'b0010);
    check("t2_res_data1", res_data[31:16], 16'h22D2);
    tick();
    #3 check("t2_res_valid2", res_valid, 4'b0100);
    check("t2_res_data2", res_data[47:32], 16'h33C3);
    tick();
    #3 check("t2_res_valid3", res_valid, 4'b1000);
    check("t2_res_data3", res_data[63:48], 16'h44B4);
    tick(); tick(); tick();

    // T3: requester 1 never consumes; others keep rotating
    res_ready = 4'b1101;
    req_valid = 4'b1111;
    g0 = 0; g1 = 0;
    for (int k = 0; k < 20; k++) begin
      #3;
      if (req_ready[0]) g0++;
      if (req_ready[1]) g1++;
      tick();
    end
    check("t3_grants_req1", g1, 1);
    check("t3_grants_req0", g0, 4);
    #3 check("t3_res_valid1_held", res_valid[1], 1'b1);
    check("t3_res_data1", res_data[31:16], 16'h22D2);
    res_ready = 4'b1111;
    req_valid = 4'b0000;
    repeat (8) tick();

    // T4: wrap from 3 to 0
    req_valid = 4'b1000;
    #3 check("t4_grant3", req_ready, 4'b1000);
    tick(); req_valid = 4'b0000;
    repeat (6) tick();
    req_valid = 4'b1001;
    #3 check("t4_grant0_first", req_ready, 4'b0001);
    tick();
    #3 check("t4_grant3_next", req_ready, 4'b1000);
    tick(); req_valid = 4'b0000;
    repeat (6) tick();

    // T5: overflow goes only to the issuing requester
    set_op(1, 16'hF800, 16'h0000);
    req_valid = 4'b0010;
    tick(); req_valid = 4'b0000;
    tick(); tick(); tick();
    #3 check("t5_res_valid", res_valid, 4'b0010);
    check("t5_res_ovf", res_ovf, 4'b0010);
    check("t5_res_data1", res_data[31:16], 16'hF800);
    repeat (3) tick();

    // T6: reset with three ops in flight
    req_valid = 4'b0111;
    tick(); tick(); tick();
    req_valid = 4'b0000;
    rst = 1'b1;
    #3 check("t6_rst_req_ready", req_ready, 4'b0000);
    check("t6_rst_res_valid", res_valid, 4'b0000);
    check("t6_rst_res_data", res_data, 64'h0);
    check("t6_rst_res_ovf", res_ovf, 4'b0000);
    check("t6_rst_fpa_a", fpa_a, 16'h0000);
    check("t6_rst_fpa_b", fpa_b, 16'h0000);
    check("t6_rst_fpa_in_valid", fpa_in_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #3 check($sformatf("t6_no_result%0d", k), res_valid, 4'b0000);
      tick();
    end
    set_op(3, 16'h1234, 16'h00FF);
    req_valid = 4'b1000;
    #3 check("t6_new_ready", req_ready, 4'b1000);
    tick(); req_valid = 4'b0000;
    tick(); tick(); tick();
    #3 check("t6_new_res_valid", res_valid, 4'b1000);
    check("t6_new_res_data", res_data[63:48], 16'h12CB);
    check("t6_new_res_ovf", res_ovf, 4'b0000);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
